// File: rtl/seq_div_8_bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// valid/ready handshakes on both the operand and the result side.
module seq_div_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    // Dividend shift register; quotient bits enter from the LSB end.
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] remo_reg, remo_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] dvd_step;

    // One restoring step; the WIDTH+1 subtract keeps the borrow visible in the MSB.
    always_comb begin
        shifted  = (rem_reg << 1) | {{WIDTH{1'b0}}, dvd_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        q_bit    = ~trial[WIDTH];
        rem_step = q_bit ? trial : shifted;
        dvd_step = {dvd_reg[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dvd_next   = dvd_reg;
        dvs_next   = dvs_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        remo_next  = remo_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    dvd_next = dividend;
                    dvs_next = divisor;
                    rem_next = '0;
                    if (divisor == '0) begin
                        state_next = DONE;
                        quo_next   = '1;
                        remo_next  = dividend;
                        dbz_next   = 1'b1;
                    end else begin
                        state_next = CALC;
                        cnt_next   = CW'(WIDTH - 1);
                    end
                end
            end
            CALC: begin
                dvd_next = dvd_step;
                rem_next = rem_step;
                if (cnt_reg == '0) begin
                    state_next = DONE;
                    quo_next   = dvd_step;
                    remo_next  = rem_step[WIDTH-1:0];
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    dbz_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            remo_reg  <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dvd_reg   <= dvd_next;
            dvs_reg   <= dvs_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            remo_reg  <= remo_next;
            dbz_reg   <= dbz_next;
        end
    end

    // Handshake flags decode the state register only, so no path from out_ready.
    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quo_reg;
    assign remainder   = remo_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: doc/seq_div_8_bit.md
Name: seq_div_8_bit

Overview:
- Multi-cycle unsigned restoring divider; the inverse of the multiply path in the 8-bit add/mul/comp/sub datapath.
- Accepts one dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake.
- Sits downstream of the operand source and upstream of the Result consumer in the arithmetic unit.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (must be >= 2).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- Reset mid-operation (CALC or DONE) aborts the operation. The pending result is discarded and never presented.
- FSM states: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE (registered, no combinational path from out_ready).
- out_valid is 1 only in DONE.
- IDLE: on in_valid&&in_ready at edge T0:
  - capture dividend into the shift register and the divisor into a register; clear the partial remainder (WIDTH+1 bits).
  - if divisor==0: go to DONE, with quotient=all-ones, remainder=dividend, div_by_zero=1. out_valid is visible after T0, giving 1-cycle latency.
  - else: go to CALC, counter=WIDTH-1.
- CALC, one iteration per edge:
  - shift the partial remainder left, bringing in the dividend MSB.
  - trial-subtract the divisor; if the result is non-negative, keep it and shift in quotient bit 1, else restore and shift in 0.
  - decrement the counter.
  - the iteration with counter==0 transitions to DONE.
  - WIDTH iterations occur at edges T1..TWIDTH; out_valid is first visible after edge TWIDTH (8-cycle latency for WIDTH=8).
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
  - on out_valid&&out_ready: go to IDLE; in_ready rises the following cycle. No same-cycle accept of new operands.
  - div_by_zero is cleared on leaving DONE.
- in_valid asserted outside IDLE is ignored; operands are not sampled.
- Operand inputs may change freely after acceptance; they do not affect the result in flight.
- Arithmetic rules:
  - all operations are unsigned.
  - invariant: dividend == quotient*divisor + remainder, with remainder < divisor (nonzero divisor).
  - the trial subtract is WIDTH+1 bits wide so no carry is lost when the partial remainder MSB is set.
- Quotient and remainder outputs are registered; they update only on the transition into DONE and keep their last value in IDLE.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH iterations, handshake), plus any out_ready stall.

Test Plan:
- Reset, then dividend=200, divisor=7 -> out_valid exactly 8 cycles after accept; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=100, divisor=0 -> out_valid 1 cycle after accept; quotient=0xFF, remainder=100, div_by_zero=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid with 200/7 -> outputs hold 28/4 and in_ready stays 0. Toggle in_valid with new operands during the stall -> no effect. out_ready=1 -> in_ready=1 the next cycle.
- Reset mid-operation: assert rst at the 4th CALC cycle of 200/7 -> next cycle in_ready=1, out_valid=0, outputs 0. Then 81/9 -> quotient=9, remainder=0.
- Random: 10k random pairs, including divisor 0 -> every result matches the reference model. Back-to-back operations with out_ready always 1 -> one result per 10 cycles.
